// File: rtl/lsu_ctrl.sv
// Load/store initiator: one request at a time, line-addressed byte-banked memory cycles, extended load data.
// Build option MISALIGN_SPLIT_EN: line-crossing accesses take two memory cycles; otherwise they are rejected with resp_err.
module lsu_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int LW = ADDR_W - 2;

`ifdef MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACC0, RESP} state_t;
`endif

    state_t      state;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_signed;
`ifdef MISALIGN_SPLIT_EN
    logic [3:0]  r_behi;
    logic [31:0] lo;
`endif

    logic [3:0]  m;
    logic [7:0]  be8;
    logic        split;
    logic [31:0] wrot;

    always_comb begin
        case (req_size)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        be8   = {4'b0000, m} << req_addr[1:0];
        split = |be8[7:4];
        case (req_addr[1:0])
            2'd0:    wrot = req_wdata;
            2'd1:    wrot = {req_wdata[23:0], req_wdata[31:24]};
            2'd2:    wrot = {req_wdata[15:0], req_wdata[31:16]};
            default: wrot = {req_wdata[7:0],  req_wdata[31:8]};
        endcase
    end

    // {hi,lo} holds the two lines; shift the addressed bytes down, then trim and extend
    function automatic logic [31:0] load_ext(input logic [63:0] hl, input logic [1:0] off,
                                             input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        sh = 32'(hl >> {off, 3'b000});
        case (size)
            2'b00:   load_ext = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   load_ext = {{16{sgn & sh[15]}}, sh[15:0]};
            default: load_ext = sh;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            r_off      <= '0;
            r_size     <= '0;
            r_signed   <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            r_behi     <= '0;
            lo         <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    r_off     <= req_addr[1:0];
                    r_size    <= req_size;
                    r_signed  <= req_signed;
                    mem_addr  <= req_addr[ADDR_W-1:2];
                    mem_wdata <= wrot;
`ifdef MISALIGN_SPLIT_EN
                    state     <= ACC0;
                    mem_we    <= req_we;
                    mem_be    <= be8[3:0];
                    r_behi    <= be8[7:4];
`else
                    if (split) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        state  <= ACC0;
                        mem_we <= req_we;
                        mem_be <= be8[3:0];
                    end
`endif
                end
                ACC0: begin
`ifdef MISALIGN_SPLIT_EN
                    if (r_behi != 4'b0000) begin
                        state    <= ACC1;
                        lo       <= mem_rdata;
                        mem_addr <= mem_addr + LW'(1);
                        mem_be   <= r_behi;
                    end else
`endif
                    begin
                        state      <= RESP;
                        mem_we     <= 1'b0;
                        mem_be     <= '0;
                        resp_valid <= 1'b1;
                        resp_rdata <= mem_we ? 32'd0 : load_ext({32'd0, mem_rdata}, r_off, r_size, r_signed);
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                ACC1: begin
                    state      <= RESP;
                    mem_we     <= 1'b0;
                    mem_be     <= '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= mem_we ? 32'd0 : load_ext({mem_rdata, lo}, r_off, r_size, r_signed);
                end
`endif
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-banked memory model; covers both MISALIGN_SPLIT_EN builds.
module tb_lsu_ctrl;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    lsu_ctrl #(.ADDR_W(12)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clock)
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];

    int nchk = 0, nerr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // per-cycle capture after the handshake edge; index k = k-th cycle after it
    logic [9:0]  c_addr [1:6];
    logic [3:0]  c_be   [1:6];
    logic        c_we   [1:6];
    logic        c_rdy  [1:6];
    logic [31:0] c_wd   [1:6];
    int          lat;
    logic [31:0] rd;
    logic        er;

    task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [11:0] a, input logic [31:0] wd);
        @(negedge clock);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0; rd = 'x; er = 1'bx;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clock);
            c_addr[k] = mem_addr; c_be[k] = mem_be; c_we[k] = mem_we;
            c_rdy[k] = req_ready; c_wd[k] = mem_wdata;
            if (resp_valid) begin lat = k; rd = resp_rdata; er = resp_err; end
        end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 12'h010; req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_ready", req_ready, 1);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_be", mem_be, 0);
        end
        check("rst_mem_addr", mem_addr, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        reset_n = 1'b1; req_valid = 1'b0;
        @(negedge clock);

        // aligned word store/load
        xact(1, 2'b10, 0, 12'h010, 32'hDEADBEEF);
        check("sw_line", c_addr[1], 10'h004);
        check("sw_be", c_be[1], 4'b1111);
        check("sw_we", c_we[1], 1);
        check("sw_wdata", c_wd[1], 32'hDEADBEEF);
        check("sw_busy", c_rdy[1], 0);
        check("sw_lat", lat, 2);
        check("sw_rdata", rd, 0);
        check("sw_resp_we", c_we[2], 0);
        check("sw_resp_be", c_be[2], 0);
        check("sw_mem", mem[4], 32'hDEADBEEF);
        xact(0, 2'b10, 0, 12'h010, 0);
        check("lw_we", c_we[1], 0);
        check("lw_lat", lat, 2);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", er, 0);

        // byte and half lanes
        xact(1, 2'b00, 0, 12'h013, 32'h00000080);
        check("sb_be", c_be[1], 4'b1000);
        check("sb_wdata", c_wd[1][31:24], 8'h80);
        xact(0, 2'b00, 1, 12'h013, 0);
        check("lb_rdata", rd, 32'hFFFFFF80);
        xact(0, 2'b00, 0, 12'h013, 0);
        check("lbu_rdata", rd, 32'h00000080);
        xact(1, 2'b01, 0, 12'h012, 32'h00008001);
        check("sh_be", c_be[1], 4'b1100);
        check("sh_wdata", c_wd[1], 32'h80010000);
        xact(0, 2'b01, 1, 12'h012, 0);
        check("lh_rdata", rd, 32'hFFFF8001);
        xact(0, 2'b01, 0, 12'h012, 0);
        check("lhu_rdata", rd, 32'h00008001);
        xact(0, 2'b10, 0, 12'h010, 0);
        check("lw_merge", rd, 32'h8001BEEF);
        // misaligned half inside one line never splits
        xact(0, 2'b01, 1, 12'h011, 0);
        check("lh_mid_be", c_be[1], 4'b0110);
        check("lh_mid_lat", lat, 2);
        check("lh_mid_rdata", rd, 32'h000001BE);

`ifdef MISALIGN_SPLIT_EN
        xact(1, 2'b10, 0, 12'h021, 32'h11223344);
        check("ssw_l0", c_addr[1], 10'h008);
        check("ssw_be0", c_be[1], 4'b1110);
        check("ssw_l1", c_addr[2], 10'h009);
        check("ssw_be1", c_be[2], 4'b0001);
        check("ssw_we1", c_we[2], 1);
        check("ssw_lat", lat, 3);
        check("ssw_err", er, 0);
        check("ssw_mem0", mem[8], 32'h22334400);
        check("ssw_mem1", mem[9], 32'h00000011);
        xact(0, 2'b10, 0, 12'h021, 0);
        check("slw_lat", lat, 3);
        check("slw_rdata", rd, 32'h11223344);
        xact(1, 2'b01, 0, 12'hFFF, 32'h0000ABCD);
        check("wrap_l0", c_addr[1], 10'h3FF);
        check("wrap_be0", c_be[1], 4'b1000);
        check("wrap_l1", c_addr[2], 10'h000);
        check("wrap_be1", c_be[2], 4'b0001);
        xact(0, 2'b01, 0, 12'hFFF, 0);
        check("wrap_lhu", rd, 32'h0000ABCD);

        // abort in ACC1 of a split load
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 12'h021;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("abort_acc0", mem_addr, 10'h008);
        @(negedge clock);
        check("abort_acc1", mem_addr, 10'h009);
        reset_n = 1'b0;
`else
        xact(0, 2'b10, 0, 12'h002, 0);
        check("err_lat", lat, 1);
        check("err_flag", er, 1);
        check("err_rdata", rd, 0);
        check("err_be", c_be[1], 0);
        xact(1, 2'b10, 0, 12'h021, 32'h11223344);
        check("err_sw_lat", lat, 1);
        check("err_sw_we", c_we[1], 0);
        check("err_sw_flag", er, 1);
        check("err_sw_mem", mem[8], 0);
        xact(1, 2'b01, 0, 12'hFFF, 32'h0000ABCD);
        check("err_wrap_flag", er, 1);
        check("err_wrap_mem", mem[0], 0);

        // abort in ACC0 of an aligned load
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 12'h010;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("abort_acc0", mem_addr, 10'h004);
        reset_n = 1'b0;
`endif
        #1;
        check("abort_ready", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("abort_resp", resp_valid, 0);
            check("abort_be", mem_be, 0);
        end
        reset_n = 1'b1;
        @(negedge clock);
        check("abort_idle_ready", req_ready, 1);
        check("abort_idle_resp", resp_valid, 0);
        xact(0, 2'b10, 0, 12'h010, 0);
        check("post_abort_lw", rd, 32'h8001BEEF);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
